// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture engine: FSM encoding,
// trigger-mode codes and the pointer-width helper.
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } la_state_e;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_PAT  = 2'd1;
  localparam logic [1:0] TRIG_RISE = 2'd2;
  localparam logic [1:0] TRIG_FALL = 2'd3;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/la_capture_engine_if.sv
// Host readout bus of the capture engine.
// Handshake: rd_en is a one-cycle strobe with no backpressure; every strobe the
// engine accepts produces exactly one rd_valid pulse on the following cycle, and
// rd_data is meaningful only while rd_valid is high.
interface la_capture_engine_if #(parameter int NUM_CH = 4);
  logic              rd_en;
  logic [NUM_CH-1:0] rd_data;
  logic              rd_valid;

  modport master (output rd_en, input rd_data, input rd_valid);
  modport slave  (input rd_en, output rd_data, output rd_valid);
endinterface

// File: rtl/la_sample_ram.sv
// DEPTH x NUM_CH sample store: one write port, one registered read port.
// Only the read register is reset; the array keeps whatever was captured last.
module la_sample_ram #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NUM_CH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [NUM_CH-1:0] rdata
);

  logic [NUM_CH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/la_capture_engine.sv
// Trigger-qualified capture engine: synchronised probes, programmable sample
// tick, circular pre/post-trigger buffer and strobed oldest-first readout.
module la_capture_engine
  import la_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 64,
  parameter int PRE_TRIG = 16,
  parameter int DIV_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               abort,
  input  logic [NUM_CH-1:0]  ch_in,
  input  logic [1:0]         trig_mode,
  input  logic [NUM_CH-1:0]  trig_mask,
  input  logic [NUM_CH-1:0]  trig_value,
  input  logic [DIV_W-1:0]   clk_div,
  la_capture_engine_if.slave rd_bus,
  output logic               triggered,
  output logic               done,
  output logic [2:0]         state
);

  localparam int AW     = ptr_w(DEPTH);
  localparam int POST_N = DEPTH - PRE_TRIG;  // samples from the trigger sample on
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG == 0 ? 0 : PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
  localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);

  la_state_e         state_q, state_d;
  logic [NUM_CH-1:0] s_meta, s_sync, prev;
  logic              prev_valid, arm_q, triggered_q, rd_valid_q;
  logic [DIV_W-1:0]  div_cnt, div_lim;
  logic [AW-1:0]     wr_ptr, rd_ptr, trig_ptr, pre_cnt, post_cnt, rd_cnt;
  logic              tick, hit, start, wr_en, trig_fire, rd_go;

  always_comb begin
    hit = 1'b0;
    case (trig_mode)
      TRIG_IMM:  hit = 1'b1;
      TRIG_PAT:  hit = ((s_sync & trig_mask) == (trig_value & trig_mask));
      TRIG_RISE: hit = prev_valid && (|(s_sync & ~prev & trig_mask));
      TRIG_FALL: hit = prev_valid && (|(~s_sync & prev & trig_mask));
      default:   hit = 1'b0;
    endcase
  end

  // abort outranks every other event, so it masks all strobes below.
  always_comb begin
    state_d   = state_q;
    tick      = (state_q != ST_IDLE) && (div_cnt == div_lim);
    start     = 1'b0;
    wr_en     = 1'b0;
    trig_fire = 1'b0;
    rd_go     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start = arm && !arm_q && !abort;
        if (start) state_d = (PRE_TRIG == 0) ? ST_WAIT_TRIG : ST_PREFILL;
      end
      ST_PREFILL: begin
        wr_en = tick && !abort;
        if (tick && pre_cnt == PRE_LAST) state_d = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        wr_en     = tick && !abort;
        trig_fire = tick && hit && !abort;
        if (tick && hit) state_d = (POST_N == 1) ? ST_DONE : ST_POST;
      end
      ST_POST: begin
        wr_en = tick && !abort;
        if (tick && post_cnt == POST_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        rd_go = rd_bus.rd_en && !abort;
        if (rd_go && rd_cnt == RD_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q       <= 1'b0;
      s_meta      <= '0;
      s_sync      <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      div_cnt     <= '0;
      div_lim     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trig_ptr    <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      rd_cnt      <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      arm_q      <= arm;
      s_meta     <= ch_in;
      s_sync     <= s_meta;
      rd_valid_q <= rd_go;
      // The limit is re-latched only at a wrap, so clk_div edits never cut a period short.
      if (state_q == ST_IDLE || tick) begin
        div_cnt <= '0;
        div_lim <= clk_div;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (start) begin
        wr_ptr     <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        rd_cnt     <= '0;
        prev_valid <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr     <= wr_ptr + AW'(1);
        prev       <= s_sync;
        prev_valid <= 1'b1;
        if (state_q == ST_PREFILL) pre_cnt  <= pre_cnt + AW'(1);
        if (state_q == ST_POST)    post_cnt <= post_cnt + AW'(1);
      end
      if (trig_fire) begin
        trig_ptr    <= wr_ptr;
        post_cnt    <= AW'(1);
        triggered_q <= 1'b1;
      end
      // Oldest retained sample sits PRE_TRIG slots behind the trigger sample.
      if (state_q != ST_DONE && state_d == ST_DONE)
        rd_ptr <= (trig_fire ? wr_ptr : trig_ptr) - AW'(PRE_TRIG);
      if (rd_go) begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_cnt <= rd_cnt + AW'(1);
      end
      if (state_d == ST_IDLE) triggered_q <= 1'b0;
    end
  end

  la_sample_ram #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (s_sync),
    .re    (rd_go),
    .raddr (rd_ptr),
    .rdata (rd_bus.rd_data)
  );

  assign rd_bus.rd_valid = rd_valid_q;
  assign triggered       = triggered_q;
  assign done            = (state_q == ST_DONE);
  assign state           = state_q;

endmodule

// File: tb/tb_la_capture_engine.sv
// Directed bench for la_capture_engine: two instances (PRE_TRIG=2 and PRE_TRIG=0),
// expected read data queued at stimulus time and checked by per-instance monitors.
module tb_la_capture_engine;
  import la_pkg::*;

  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         arm, arm_b, abort;
  logic [W-1:0] ch_in, trig_mask, trig_value;
  logic [1:0]   trig_mode;
  logic [7:0]   clk_div;
  logic         triggered_a, done_a, triggered_b, done_b;
  logic [2:0]   state_a, state_b;

  la_capture_engine_if #(.NUM_CH(W)) bus_a ();
  la_capture_engine_if #(.NUM_CH(W)) bus_b ();

  la_capture_engine #(.NUM_CH(W), .DEPTH(8), .PRE_TRIG(2), .DIV_W(8)) dut_a (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .ch_in(ch_in),
    .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
    .clk_div(clk_div), .rd_bus(bus_a.slave), .triggered(triggered_a),
    .done(done_a), .state(state_a)
  );

  la_capture_engine #(.NUM_CH(W), .DEPTH(8), .PRE_TRIG(0), .DIV_W(8)) dut_b (
    .clk(clk), .rst(rst), .arm(arm_b), .abort(abort), .ch_in(ch_in),
    .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
    .clk_div(clk_div), .rd_bus(bus_b.slave), .triggered(triggered_b),
    .done(done_b), .state(state_b)
  );

  // scoreboard
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.rd_valid === 1'b1) begin
      if (exp_q_a.size() == 0) check("rd_a_unexpected_valid", 1, 0);
      else check("rd_a_data", bus_a.rd_data, exp_q_a.pop_front());
    end
    if (bus_b.rd_valid === 1'b1) begin
      if (exp_q_b.size() == 0) check("rd_b_unexpected_valid", 1, 0);
      else check("rd_b_data", bus_b.rd_data, exp_q_b.pop_front());
    end
  end

  // driver tasks
  task automatic wait_state(input int which, input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (((which == 0) ? state_a : state_b) !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (which == 0) ? state_a : state_b, st);
  endtask

  // Holds rd_en for n cycles starting at the current negedge; ends one negedge after the last read.
  task automatic read_n(input int which, input int n, input string name);
    if (which == 0) bus_a.rd_en = 1'b1; else bus_b.rd_en = 1'b1;
    repeat (n) @(negedge clk);
    bus_a.rd_en = 1'b0;
    bus_b.rd_en = 1'b0;
    check({name, "_idle_after_read"}, (which == 0) ? state_a : state_b, ST_IDLE);
    check({name, "_done_clear"}, (which == 0) ? done_a : done_b, 0);
    check({name, "_trig_clear"}, (which == 0) ? triggered_a : triggered_b, 0);
  endtask

  // Immediate-mode capture with ch_in counting every cycle; arm seen with ch_in=3,
  // two synchroniser flops put sample value 2 in the first buffer slot.
  task automatic count_capture(input string name);
    trig_mode = TRIG_IMM;
    clk_div   = 8'd0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 11) check({name, "_done_early"}, done_a, 0);
      if (i == 12) check({name, "_done"}, done_a, 1);
      ch_in = W'(i);
      arm   = (i == 3);
    end
    for (int v = 2; v < 10; v++) exp_q_a.push_back(W'(v));
    read_n(0, 8, name);
  endtask

  function automatic logic [W-1:0] v3(input int k);
    return W'((k & 3) | ((k >= 5) ? 4 : 0) | ((k >= 7) ? 8 : 0));
  endfunction

  logic [W-1:0] seq6 [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; arm_b = 1'b0; abort = 1'b0; ch_in = '0;
    trig_mode = TRIG_IMM; trig_mask = '0; trig_value = '0; clk_div = '0;
    bus_a.rd_en = 1'b0; bus_b.rd_en = 1'b0;
    @(negedge clk);
    check("reset_state", state_a, ST_IDLE);
    check("reset_rd_data", bus_a.rd_data, 0);
    check("reset_rd_valid", bus_a.rd_valid, 0);
    check("reset_triggered", triggered_a, 0);
    check("reset_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: immediate trigger, every cycle a sample
    count_capture("t1");

    // 2: pattern 4'hA over a 0..15 count; window 8..F
    trig_mode = TRIG_PAT; trig_mask = 4'hF; trig_value = 4'hA; clk_div = 8'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 12) check("t2_trig_before_A", triggered_a, 0);
      if (i == 13) check("t2_trig_after_A", triggered_a, 1);
      ch_in = W'(i);
      arm   = (i == 1);
    end
    wait_state(0, ST_DONE, 20, "t2_done_state");
    for (int v = 8; v < 16; v++) exp_q_a.push_back(W'(v));
    read_n(0, 8, "t2");

    // 3: rising edge on ch_in[2] at tick 5, one tick per 4 cycles
    trig_mode = TRIG_RISE; trig_mask = 4'b0100; clk_div = 8'd3;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      ch_in = v3(k);
      arm   = (k == 1);
      @(negedge clk);
      arm = 1'b0;
      repeat (2) @(negedge clk);
    end
    wait_state(0, ST_DONE, 20, "t3_done_state");
    for (int k = 3; k <= 10; k++) exp_q_a.push_back(v3(k));
    read_n(0, 8, "t3");

    // 4: abort in POST, then abort together with rd_en in DONE
    trig_mode = TRIG_IMM; clk_div = 8'd2;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    wait_state(0, ST_POST, 50, "t4_reach_post");
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("t4_post_abort_state", state_a, ST_IDLE);
    check("t4_post_abort_done", done_a, 0);
    check("t4_post_abort_trig", triggered_a, 0);
    clk_div = 8'd0;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    wait_state(0, ST_DONE, 50, "t4_reach_done");
    bus_a.rd_en = 1'b1; abort = 1'b1;
    @(negedge clk); bus_a.rd_en = 1'b0; abort = 1'b0;
    check("t4_done_abort_state", state_a, ST_IDLE);
    check("t4_done_abort_done", done_a, 0);
    check("t4_done_abort_valid", bus_a.rd_valid, 0);

    // 5: asynchronous reset mid-POST, then a normal capture
    clk_div = 8'd3;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    wait_state(0, ST_POST, 80, "t5_reach_post");
    #2 rst = 1'b1;
    #1;
    check("t5_async_state", state_a, ST_IDLE);
    check("t5_async_rd_data", bus_a.rd_data, 0);
    check("t5_async_valid", bus_a.rd_valid, 0);
    check("t5_async_trig", triggered_a, 0);
    check("t5_async_done", done_a, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    count_capture("t5_recapture");

    // 6: PRE_TRIG=0 falling edge on ch_in[0]; no edge while held low
    trig_mode = TRIG_FALL; trig_mask = 4'b0001; trig_value = '0; clk_div = 8'd0;
    ch_in = '0;
    @(negedge clk); arm_b = 1'b1;
    @(negedge clk); arm_b = 1'b0;
    repeat (10) @(negedge clk);
    bus_b.rd_en = 1'b1;
    repeat (2) @(negedge clk);
    bus_b.rd_en = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_wait_state", state_b, ST_WAIT_TRIG);
    check("t6_no_trig", triggered_b, 0);
    seq6 = '{4'h3, 4'h3, 4'h3, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'h2, 4'h0};
    for (int i = 0; i < 11; i++) begin
      ch_in = seq6[i];
      @(negedge clk);
    end
    wait_state(1, ST_DONE, 20, "t6_done_state");
    for (int i = 3; i < 11; i++) exp_q_b.push_back(seq6[i]);
    read_n(1, 8, "t6");

    // final report
    repeat (3) @(negedge clk);
    check("queue_a_drained", exp_q_a.size(), 0);
    check("queue_b_drained", exp_q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
